// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Groups the fetch unit's instruction-memory read port, its redirect
//   input and its decode-side valid/ready channel.
//   master : the fetch unit (drives inst_address and the out_* signals)
//   slave  : the environment (memory, branch resolution and decode)
//
//   inst_address   [15:0]  address presented to instruction memory
//   read_data      [31:0]  combinational word returned for inst_address
//   fetch_en               allows new fetches to be captured
//   redirect_valid         one-cycle flush-and-jump pulse
//   redirect_pc    [15:0]  jump target, sampled with redirect_valid
//   out_valid              queue head holds a valid entry
//   out_ready              decode accepts the head this cycle
//   out_inst       [31:0]  instruction word at the queue head
//   out_pc         [15:0]  PC of out_inst
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic [15:0] inst_address;
  logic [31:0] read_data;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [15:0] out_pc;

  modport master (
    output inst_address, out_valid, out_inst, out_pc,
    input  read_data, fetch_en, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  inst_address, out_valid, out_inst, out_pc,
    output read_data, fetch_en, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Read-side master of the instruction memory. Owns the PC, captures the
//   combinational read_data for the current PC and buffers {pc, inst} pairs
//   in a 2-entry queue that decode drains through a valid/ready handshake.
//   A redirect flushes the queue and reloads the PC.
//
//   Parameters
//     RESET_PC  PC loaded by reset
//     PC_STEP   PC increment per captured fetch (word-indexed memory)
//
//   Ports
//     clk       rising-edge clock
//     reset_n   synchronous active-low reset
//     bus       instruction_fetch_unit_if.master (memory, redirect, decode)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  instruction_fetch_unit_if.master        bus
);

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  fetch_entry_t [DEPTH-1:0] r_fifo;
  logic [15:0]              r_pc;
  logic                     r_head;
  logic                     r_tail;
  logic [1:0]               r_count;

  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  fetch_entry_t             w_head_entry;
  fetch_entry_t             w_new_entry;

  assign w_full        = (r_count == 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign w_pop         = bus.out_valid & bus.out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept
  // the next fetch and a 1-per-cycle stream never stalls.
  assign w_push        = bus.fetch_en & ~bus.redirect_valid & (~w_full | w_pop);

  assign bus.inst_address = r_pc;

  // Head contents are shown even when empty; they simply go stale.
  assign w_head_entry  = r_fifo[r_head];
  assign bus.out_pc    = w_head_entry.pc;
  assign bus.out_inst  = w_head_entry.inst;

  assign w_new_entry   = '{pc: r_pc, inst: bus.read_data};

  // Entry storage: only the slot under the tail pointer is written.
  // w_push already excludes redirect cycles, so a flush never captures.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fifo <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_tail == i[0])) r_fifo[i] <= w_new_entry;
      end
    end
  end

  // PC, pointers and occupancy. Redirect outranks push and pop: the head
  // offered in that cycle is dropped even if decode raised out_ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (bus.redirect_valid) begin
      r_pc    <= bus.redirect_pc;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + PC_STEP;
        r_tail <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

The instruction fetch unit is the read-side master of the instruction memory. It owns the program counter and drives `inst_address`. It captures the combinational `read_data` returned for that address and buffers {pc, instruction} pairs in a 2-entry queue. Decode pulls those pairs through a valid/ready handshake, and the unit also handles control-flow redirects and backpressure.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `PC_STEP`, 16'd1, PC increment per fetch. Memory is word-indexed: one 32-bit word per address.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `inst_address`  out  16  address to instruction memory; equals the PC register (combinational from it).
- `read_data`  in  32  instruction word from memory; valid in the same cycle as `inst_address`.
- `fetch_en`  in  1  when low, no new fetches are captured; the queue still drains.
- `redirect_valid`  in  1  one-cycle pulse: flush and jump.
- `redirect_pc`  in  16  target PC; sampled when `redirect_valid`=1.
- `out_valid`  out  1  queue head holds a valid entry.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_inst`  out  32  instruction word at the queue head.
- `out_pc`  out  16  PC of `out_inst`.

## Operation
- State:
  - PC register (16b).
  - 2-entry FIFO of {pc[15:0], inst[31:0]} with head/tail pointers (1b each).
  - Occupancy count (0..2).
- Definitions:
  - pop = `out_valid` & `out_ready`.
  - push = `fetch_en` & !`redirect_valid` & (count<2 | pop).
- Push:
  - Writes {PC, `read_data`} at the tail.
  - PC <= PC + `PC_STEP`, modulo 2^16 (16'hFFFF + 1 wraps to 16'h0000).
- No push: PC holds.
- Pop: head advances.
- Count update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - Both or neither: count unchanged.
- Full with pop in the same cycle: push is permitted, so a 1-per-cycle stream is sustained at count=2.
- `out_valid` = (count != 0).
- `out_inst` and `out_pc` come from the head entry.
  - When count=0 they hold the last head contents (0 after reset).
  - Bench checks them only when `out_valid`=1.
- Redirect (highest priority, overrides push and pop):
  - Count <= 0; head and tail pointers <= 0.
  - PC <= `redirect_pc`.
  - No entry is captured in the redirect cycle, even if `out_ready`=1. The head offered that cycle is discarded, not consumed.
- `fetch_en`=0: no push; pops continue; PC frozen.
- Reset (`reset_n`=0 at a rising edge) overrides everything, including during streaming or redirect:
  - PC <= `RESET_PC`; count, head and tail <= 0.
  - All FIFO entries <= 0; `out_valid`=0; `out_inst`=0; `out_pc`=0.
  - `inst_address`=`RESET_PC` from the first post-reset cycle.
- Data is only ever sampled from `read_data` in a push cycle; no assumption is made about memory contents. Uninitialized words pass through unchanged.

## Timing
- Fetch latency: memory word at PC P is captured at the end of cycle N (push). `out_valid`=1 with `out_pc`=P in cycle N+1.
- After reset deassert with `fetch_en`=1 and `out_ready`=1:
  - Cycle 0 `inst_address`=`RESET_PC`.
  - Cycle 1 `out_valid`=1.
  - Throughput thereafter: 1 instruction/cycle.
- Redirect in cycle N:
  - Cycle N+1: `inst_address`=`redirect_pc`, `out_valid`=0.
  - Cycle N+2: `out_pc`=`redirect_pc`.
  - Redirect penalty: 2 bubbles.
- Backpressure: with `out_ready`=0, exactly 2 pushes occur, then PC stalls. `out_*` stays stable while `out_valid`=1 and `out_ready`=0.
- After `out_ready` returns: next cycle pops the head and pushes the next PC simultaneously; no bubble.
- Order guarantee: `out_pc` sequence seen by decode is strictly RESET_PC/redirect target, +PC_STEP, +2*PC_STEP, …, with no duplicates or gaps.

## Test plan
- Reset then stream:
  - Stimulus: memory preloaded `mem[i]`=32'hA000_0000+i, `fetch_en`=1, `out_ready`=1.
  - Response: `out_valid` rises cycle 1; `out_pc`=0,1,2,3… on consecutive cycles; `out_inst`=32'hA000_0000, …0001, …
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles from start.
  - Response: `inst_address` stops at 2; head stays pc=0/32'hA000_0000.
  - Release `out_ready` → 0,1,2,3 delivered on consecutive cycles with no gap or duplicate.
- Redirect mid-stream:
  - Stimulus: at count=2, pulse `redirect_valid` with `redirect_pc`=16'h0040 while `out_ready`=1.
  - Response: next cycle `out_valid`=0, `inst_address`=16'h0040; following cycle `out_pc`=16'h0040, `out_inst`=`mem[0x40]`. Old entries are never delivered.
- PC wrap:
  - Stimulus: redirect to 16'hFFFF.
  - Response: delivered `out_pc` sequence is 16'hFFFF, 16'h0000, 16'h0001.
- Fetch gating:
  - Stimulus: `fetch_en`=0 for 3 cycles with `out_ready`=1.
  - Response: queue drains to `out_valid`=0; `inst_address` frozen; resumes at the same PC with no skipped address.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 for 1 cycle while count=2 and a redirect is pending.
  - Response: next cycle `out_valid`=0, `out_pc`=0, `out_inst`=0, `inst_address`=`RESET_PC`. Streaming restarts from `RESET_PC`.
